// File: rtl/regfile_8x16_if.sv
// Register file access bus: two read ports, one write port, debug tap of r1.
interface regfile_8x16_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] raddr_1;
  logic [DATA_W-1:0] rdata_1;
  logic [ADDR_W-1:0] raddr_2;
  logic [DATA_W-1:0] rdata_2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] dbg_r1;

  // Decode/writeback side drives addresses and write data.
  modport master (
    output raddr_1, raddr_2, we, waddr, wdata,
    input  rdata_1, rdata_2, dbg_r1
  );

  // Register file side.
  modport slave (
    input  raddr_1, raddr_2, we, waddr, wdata,
    output rdata_1, rdata_2, dbg_r1
  );
endinterface

// File: rtl/regfile_8x16.sv
// 8x16 register file: r0 reads zero, two combinational read ports with
// same-cycle write-through bypass, one synchronous write port, r1 debug tap.
module regfile_8x16 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_8x16_if.slave   bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  // Storage for r1..r(NREG-1); r0 has no storage.
  logic [DATA_W-1:0] r_regs [1:NREG-1];

  logic              w_wr_valid;
  logic [DATA_W-1:0] w_rdata_1;
  logic [DATA_W-1:0] w_rdata_2;

  // A write is only real when enabled and not targeting r0.
  assign w_wr_valid = bus.we && (bus.waddr != '0);

  // Register update: synchronous reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[bus.waddr] <= bus.wdata;
    end
  end

  // Read port 1: r0 is zero, pending write to the same register bypasses.
  always_comb begin
    w_rdata_1 = '0;
    if (bus.raddr_1 != '0) begin
      if (w_wr_valid && (bus.waddr == bus.raddr_1)) begin
        w_rdata_1 = bus.wdata;
      end else begin
        w_rdata_1 = r_regs[bus.raddr_1];
      end
    end
  end

  // Read port 2: identical rules to port 1.
  always_comb begin
    w_rdata_2 = '0;
    if (bus.raddr_2 != '0) begin
      if (w_wr_valid && (bus.waddr == bus.raddr_2)) begin
        w_rdata_2 = bus.wdata;
      end else begin
        w_rdata_2 = r_regs[bus.raddr_2];
      end
    end
  end

  assign bus.rdata_1 = w_rdata_1;
  assign bus.rdata_2 = w_rdata_2;
  // Debug view shows stored r1 only, never the bypass value.
  assign bus.dbg_r1  = r_regs[1];

endmodule

// File: tb/tb_regfile_8x16.sv
// Self-checking bench for regfile_8x16: directed vector table, a reset
// mid-operation sequence, and randomized traffic against an array model.
module tb_regfile_8x16;

  logic clk;
  logic rst_n;

  regfile_8x16_if bus_if ();

  regfile_8x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference storage: plain array, r0 kept at zero.
  logic [15:0] mem [8];

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] edbg;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Read value the register file should present for address a this cycle.
  function automatic logic [15:0] exp_rd(input logic [2:0] a, input logic we,
                                         input logic [2:0] wa, input logic [15:0] wd);
    if (a == 3'd0) return 16'h0000;
    if (we && (wa == a)) return wd;
    return mem[a];
  endfunction

  // Drive one cycle, check combinational outputs mid-cycle, then advance
  // the model across the clock edge.
  task automatic step(input string name, input logic rst, input logic we,
                      input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] ra1, input logic [2:0] ra2,
                      input logic [15:0] e1, input logic [15:0] e2,
                      input logic [15:0] edbg);
    @(negedge clk);
    rst_n          = rst;
    bus_if.we      = we;
    bus_if.waddr   = wa;
    bus_if.wdata   = wd;
    bus_if.raddr_1 = ra1;
    bus_if.raddr_2 = ra2;
    #2;
    check({name, ".rdata_1"}, bus_if.rdata_1, e1);
    check({name, ".rdata_2"}, bus_if.rdata_2, e2);
    check({name, ".dbg_r1"},  bus_if.dbg_r1,  edbg);
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    end else if (we && (wa != 3'd0)) begin
      mem[wa] = wd;
    end
  endtask

  // Step whose expectations come from the model.
  task automatic step_model(input string name, input logic rst, input logic we,
                            input logic [2:0] wa, input logic [15:0] wd,
                            input logic [2:0] ra1, input logic [2:0] ra2);
    step(name, rst, we, wa, wd, ra1, ra2,
         exp_rd(ra1, we, wa, wd), exp_rd(ra2, we, wa, wd), mem[1]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    rst_n          = 1'b0;
    bus_if.we      = 1'b0;
    bus_if.waddr   = 3'd0;
    bus_if.wdata   = 16'h0000;
    bus_if.raddr_1 = 3'd0;
    bus_if.raddr_2 = 3'd0;

    //         rst   we    wa    wd        ra1   ra2   e1        e2        edbg
    vecs[0]  = '{1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd7, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd7, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 16'hFFFF, 3'd3, 3'd7, 16'h0000, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd1, 16'h1234, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 16'hBEEF, 3'd5, 3'd1, 16'h1234, 16'hBEEF, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd1, 16'h1234, 16'hBEEF, 16'hBEEF};
    vecs[6]  = '{1'b1, 1'b1, 3'd0, 16'hAAAA, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd1, 16'h1234, 16'hBEEF, 16'hBEEF};
    vecs[8]  = '{1'b1, 1'b1, 3'd2, 16'h0001, 3'd2, 3'd3, 16'h0001, 16'h0000, 16'hBEEF};
    vecs[9]  = '{1'b1, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd2, 16'h5555, 16'h5555, 16'hBEEF};
    vecs[10] = '{1'b1, 1'b0, 3'd2, 16'h0000, 3'd2, 3'd5, 16'h5555, 16'h1234, 16'hBEEF};
    vecs[11] = '{1'b1, 1'b0, 3'd4, 16'h9999, 3'd4, 3'd4, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[12] = '{1'b1, 1'b0, 3'd4, 16'h9999, 3'd4, 3'd4, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[13] = '{1'b1, 1'b0, 3'd4, 16'h9999, 3'd4, 3'd4, 16'h0000, 16'h0000, 16'hBEEF};
    vecs[14] = '{1'b1, 1'b1, 3'd4, 16'h7777, 3'd4, 3'd5, 16'h7777, 16'h1234, 16'hBEEF};
    vecs[15] = '{1'b1, 1'b0, 3'd4, 16'h9999, 3'd4, 3'd3, 16'h7777, 16'h0000, 16'hBEEF};

    // Establish a known state before the checked vectors.
    @(posedge clk);
    #1;

    for (int v = 0; v < 16; v++) begin
      step($sformatf("vec%0d", v), vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd,
           vecs[v].ra1, vecs[v].ra2, vecs[v].e1, vecs[v].e2, vecs[v].edbg);
    end

    // Fill r1..r7 with 0x0101..0x0707, checking the bypass on each write.
    for (int i = 1; i < 8; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 1'b1, 3'(i), 16'(i * 16'h0101), 3'(i), 3'd0,
           16'(i * 16'h0101), 16'h0000, (i == 1) ? 16'hBEEF : 16'h0101);
    end
    for (int i = 0; i < 8; i++) begin
      step($sformatf("filled%0d", i), 1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i),
           16'(i * 16'h0101), 16'((7 - i) * 16'h0101), 16'h0101);
    end

    // One-edge reset pulse with a coincident write that must be dropped.
    step("rst_pulse", 1'b0, 1'b1, 3'd6, 16'h6666, 3'd6, 3'd7, 16'h6666, 16'h0707, 16'h0101);
    for (int i = 0; i < 8; i++) begin
      step($sformatf("post_rst%0d", i), 1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i),
           16'h0000, 16'h0000, 16'h0000);
    end
    step("post_rst_wr", 1'b1, 1'b1, 3'd3, 16'hC3C3, 3'd3, 3'd1, 16'hC3C3, 16'h0000, 16'h0000);
    step("post_rst_rd", 1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hC3C3, 16'hC3C3, 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step_model($sformatf("rand%0d", n),
                 ($urandom_range(0, 31) != 0),
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
